lagarto_pmu_counter_bank: RTL and testbench
===========================================

# lagarto_pmu_counter_bank

Parametrised performance-monitor counter bank that turns the per-cycle Lagarto PMU event vector (bit 0 = constant 1 for cycle counting, upper bits = core events) into software-visible counters. It sits next to the core wrapper, consumes the `pmu_sig` event bus, and exposes a single-port register interface to the CSR/MMIO side. It adds behaviour the bare event bus lacks:

- per-event enable masking
- global freeze
- wrap detection with sticky overflow flags
- a maskable overflow interrupt
- optional atomic snapshot

## Interface

Parameters:
- `NUM_EVENTS`, default 25: number of event inputs and counters; legal range 1..32.
- `CNT_WIDTH`, default 48: counter width; legal range 8..64.
- `ADDR_WIDTH`, default 8: register word-address width; must be ≥ 7.

Ports:
- `clk_i`  in  1: core clock.
- `rst_i`  in  1: reset, synchronous, active-high. One clock; all state is reset on the `clk_i` edge while `rst_i`=1.
- `pmu_sig_i`  in  `NUM_EVENTS`: event pulses, one bit per event, level per cycle.
- `req_i`  in  1: register access request, single-cycle.
- `we_i`  in  1: 1 = write, 0 = read; qualified by `req_i`.
- `addr_i`  in  `ADDR_WIDTH`: word address.
- `wdata_i`  in  64: write data.
- `rdata_o`  out  64: read data; valid when `rvalid_o`=1.
- `rvalid_o`  out  1: read response strobe.
- `irq_o`  out  1: overflow interrupt, level.

## Operation

Register map (word addresses):
- 0 CTRL
  - bit0 `GEN`: global enable, R/W.
  - bit1 `CLR`: clear-all, write-1 pulse, reads 0.
  - bit2 `SNAP`: snapshot, write-1 pulse, reads 0. Exists only under the macro.
- 1 EN: per-event enable mask, R/W. Width `NUM_EVENTS`; upper bits read 0.
- 2 OVF: sticky overflow flags, write-1-to-clear.
- 3 IRQM: overflow interrupt mask, R/W.
- 16+i CNT[i], i < `NUM_EVENTS`.
  - Read: zero-extended to 64 bits.
  - Write: loads `wdata_i[CNT_WIDTH-1:0]`.
- 64+i SNAPSHOT[i]: read-only, macro only.
- Unmapped addresses: reads return 0; writes are ignored; `rvalid_o` still pulses.

Event path:
- `pmu_sig_i` is registered into `ev_q` (one pipeline stage).
- CNT[i] increments by 1 when `ev_q[i] & EN[i] & GEN`.

Wrap:
- Increment from all-ones produces 0 and sets `OVF[i]` on the same edge.
- Arithmetic is modulo 2^`CNT_WIDTH`.

`irq_o` is registered: next value is `|(OVF & IRQM)`.

Priority per counter on one edge, highest first:
1. `rst_i`
2. CTRL.CLR: all CNT ← 0 and OVF ← 0.
3. CNT[i] write.
4. Increment.

A write that collides with an increment discards the increment; no OVF is set by the discarded increment.

OVF set/clear collision: a hardware set wins over a write-1-to-clear of the same bit in the same cycle.

Reset values:
- All CNT, OVF, IRQM, SNAPSHOT = 0.
- EN = all ones; GEN = 0.
- `ev_q` = 0.
- `rdata_o` = 0, `rvalid_o` = 0, `irq_o` = 0.

Reset mid-operation: everything returns to reset values on the next edge. A read in flight is dropped: no `rvalid_o` in the cycle after reset.

## Timing

- Read latency 1: request at edge N, `rdata_o`/`rvalid_o` valid for exactly one cycle after edge N+1. `rdata_o` holds its value otherwise.
- Back-to-back requests are accepted every cycle; no backpressure.
- Event to counter: event high in cycle T → `ev_q` at edge T+1 → CNT updated at edge T+2. A read issued in cycle T+2 returns the incremented value.
- Register writes take effect at the accepting edge. A write to EN/GEN in cycle T gates the `ev_q` value used at edge T+1, i.e. the registered event sampled in cycle T−1.
- Overflow to `irq_o`: OVF set at edge W, `irq_o` high after edge W+1.
- A read of CNT[i] in the same cycle as its write returns the pre-write value.

## Configuration

`LAGARTO_PMU_SNAPSHOT_EN`

Defined:
- Writing CTRL.SNAP=1 copies all CNT into SNAPSHOT[0..NUM_EVENTS-1] on that edge. The copy uses pre-update values, so the same edge's increments are excluded.
- SNAPSHOT is readable at 64+i.
- If CLR and SNAP are written together, the snapshot captures pre-clear values.

Undefined:
- No snapshot registers.
- CTRL bit2 ignored on write, reads 0.
- Addresses 64+i behave as unmapped.

## Test plan

- Reset, GEN=1, hold `pmu_sig_i`=1 for 10 cycles, then 0 → after pipeline drain, CNT[0]=10; all others 0.
- EN=0x2, GEN=1, pulse bits 1 and 2 for 5 cycles each → CNT[1]=5, CNT[2]=0. GEN=0, then pulse bit 1 → CNT[1] stays 5.
- Write CNT[3]=2^`CNT_WIDTH`−2, IRQM=0x8, event 3 high for 3 cycles:
  - CNT[3] ends at 1; OVF=0x8.
  - `irq_o` rises one cycle after the wrap edge.
  - Write OVF=0x8 → `irq_o` falls one cycle later.
- Same cycle: write CNT[5]=100 while event 5 is being counted → CNT[5]=100. Also: W1C OVF[3] coincident with a new wrap of CNT[3] → OVF[3] remains 1.
- Reads every cycle across addresses 0, 1, 16, 99, 200:
  - `rvalid_o` pulses each cycle with latency 1.
  - Unmapped addresses return 0.
  - Assert `rst_i` with a read in flight → no `rvalid_o` the next cycle.
- Macro defined, CNT[0]=50: write CTRL with SNAP=1 and CLR=1 → SNAPSHOT[0]=50, CNT[0]=0. Macro undefined: address 64 reads 0.

Source files
------------

// File: rtl/lagarto_pmu_counter_bank.sv
// Performance-monitor counter bank: per-event counters with enable mask, freeze, sticky overflow, irq.
// Latency: events count 2 edges after pmu_sig_i; register reads return 1 cycle after the request.
// Backpressure: none; accepts one register access every cycle. Optional snapshot: LAGARTO_PMU_SNAPSHOT_EN.
module lagarto_pmu_counter_bank #(
    parameter int NUM_EVENTS = 25,
    parameter int CNT_WIDTH  = 48,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_EVENTS-1:0] pmu_sig_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [63:0]           wdata_i,
    output logic [63:0]           rdata_o,
    output logic                  rvalid_o,
    output logic                  irq_o
);

    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_EN   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_OVF  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_IRQM = ADDR_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    logic [NUM_EVENTS-1:0] ev_q;
    logic                  gen_q;
    logic [NUM_EVENTS-1:0] en_q;
    logic [NUM_EVENTS-1:0] ovf_q;
    logic [NUM_EVENTS-1:0] irqm_q;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
`ifdef LAGARTO_PMU_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0]  snap_q [NUM_EVENTS];
    logic                  snap;
`endif

    logic                  wr_en, rd_en;
    logic                  ctrl_wr, en_wr, ovf_wr, irqm_wr;
    logic                  clr, gen_eff;
    logic [NUM_EVENTS-1:0] en_eff;
    logic [NUM_EVENTS-1:0] cnt_wr, inc, ovf_set, ovf_d;
    logic [63:0]           rd_val;

    wire unused_wdata = ^wdata_i;

    always_comb begin
        wr_en   = req_i & we_i;
        rd_en   = req_i & ~we_i;
        ctrl_wr = wr_en && (addr_i == A_CTRL);
        en_wr   = wr_en && (addr_i == A_EN);
        ovf_wr  = wr_en && (addr_i == A_OVF);
        irqm_wr = wr_en && (addr_i == A_IRQM);
        clr     = ctrl_wr & wdata_i[1];
`ifdef LAGARTO_PMU_SNAPSHOT_EN
        snap    = ctrl_wr & wdata_i[2];
`endif
        // A GEN/EN write gates the registered event consumed on the same edge.
        gen_eff = ctrl_wr ? wdata_i[0] : gen_q;
        en_eff  = en_wr ? wdata_i[NUM_EVENTS-1:0] : en_q;
        cnt_wr  = '0;
        inc     = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_wr[i]  = wr_en && (addr_i == ADDR_WIDTH'(16 + i));
            inc[i]     = ev_q[i] & en_eff[i] & gen_eff;
            ovf_set[i] = inc[i] & ~cnt_wr[i] & (cnt_q[i] == CNT_MAX);
        end
        // Hardware set beats a same-cycle write-1-to-clear.
        ovf_d = clr ? '0
              : ((ovf_q & ~(ovf_wr ? wdata_i[NUM_EVENTS-1:0] : '0)) | ovf_set);
    end

    always_comb begin
        rd_val = '0;
        if (addr_i == A_CTRL) rd_val[0] = gen_q;
        if (addr_i == A_EN)   rd_val[NUM_EVENTS-1:0] = en_q;
        if (addr_i == A_OVF)  rd_val[NUM_EVENTS-1:0] = ovf_q;
        if (addr_i == A_IRQM) rd_val[NUM_EVENTS-1:0] = irqm_q;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (addr_i == ADDR_WIDTH'(16 + i)) rd_val = 64'(cnt_q[i]);
`ifdef LAGARTO_PMU_SNAPSHOT_EN
            if (addr_i == ADDR_WIDTH'(64 + i)) rd_val = 64'(snap_q[i]);
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ev_q     <= '0;
            gen_q    <= 1'b0;
            en_q     <= '1;
            ovf_q    <= '0;
            irqm_q   <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            irq_o    <= 1'b0;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i] <= '0;
`ifdef LAGARTO_PMU_SNAPSHOT_EN
                snap_q[i] <= '0;
`endif
            end
        end else begin
            ev_q     <= pmu_sig_i;
            gen_q    <= gen_eff;
            en_q     <= en_eff;
            ovf_q    <= ovf_d;
            irq_o    <= |(ovf_q & irqm_q);
            rvalid_o <= rd_en;
            if (rd_en) rdata_o <= rd_val;
            if (irqm_wr) irqm_q <= wdata_i[NUM_EVENTS-1:0];
            for (int i = 0; i < NUM_EVENTS; i++) begin
`ifdef LAGARTO_PMU_SNAPSHOT_EN
                if (snap) snap_q[i] <= cnt_q[i];
`endif
                if (clr)            cnt_q[i] <= '0;
                else if (cnt_wr[i]) cnt_q[i] <= wdata_i[CNT_WIDTH-1:0];
                else if (inc[i])    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lagarto_pmu_counter_bank.sv
// Directed bench for lagarto_pmu_counter_bank at default parameters.
module tb_lagarto_pmu_counter_bank;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [24:0] pmu_sig_i = '0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [63:0] rdata_o;
    logic        rvalid_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    lagarto_pmu_counter_bank dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .pmu_sig_i(pmu_sig_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [63:0] exp);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        req_i = 1'b0;
        check({tag, "_rvalid"}, {63'd0, rvalid_o}, 64'd1);
        check(tag, rdata_o, exp);
    endtask

    logic [7:0]  ra [5];
    logic [63:0] re [5];

    initial begin
        repeat (2) @(negedge clk_i);
        do_reset();
        check("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        check("rst_irq", {63'd0, irq_o}, 64'd0);
        rd("rst_ctrl", 8'd0, 64'd0);
        rd("rst_en", 8'd1, 64'h1FF_FFFF);
        rd("rst_ovf", 8'd2, 64'd0);
        rd("rst_irqm", 8'd3, 64'd0);
        rd("rst_cnt0", 8'd16, 64'd0);

        // Cycle counting on bit 0.
        wr(8'd0, 64'd1);
        pmu_sig_i = 25'd1;
        repeat (10) @(negedge clk_i);
        pmu_sig_i = '0;
        repeat (3) @(negedge clk_i);
        rd("cyc_cnt0", 8'd16, 64'd10);
        rd("cyc_cnt1", 8'd17, 64'd0);
        rd("cyc_cnt24", 8'd40, 64'd0);

        // Enable mask and global freeze.
        do_reset();
        wr(8'd1, 64'h2);
        wr(8'd0, 64'd1);
        pmu_sig_i = 25'h2;
        repeat (5) @(negedge clk_i);
        pmu_sig_i = 25'h4;
        repeat (5) @(negedge clk_i);
        pmu_sig_i = '0;
        repeat (3) @(negedge clk_i);
        rd("mask_cnt1", 8'd17, 64'd5);
        rd("mask_cnt2", 8'd18, 64'd0);
        wr(8'd0, 64'd0);
        pmu_sig_i = 25'h2;
        repeat (3) @(negedge clk_i);
        pmu_sig_i = '0;
        repeat (3) @(negedge clk_i);
        rd("frz_cnt1", 8'd17, 64'd5);

        // Wrap, sticky overflow and interrupt timing.
        do_reset();
        wr(8'd19, 64'h0000_FFFF_FFFF_FFFE);
        wr(8'd3, 64'h8);
        wr(8'd0, 64'd1);
        pmu_sig_i = 25'h8;
        repeat (3) @(negedge clk_i);
        pmu_sig_i = '0;
        check("irq_at_wrap", {63'd0, irq_o}, 64'd0);
        @(negedge clk_i);
        check("irq_after_wrap", {63'd0, irq_o}, 64'd1);
        repeat (2) @(negedge clk_i);
        rd("wrap_cnt3", 8'd19, 64'd1);
        rd("wrap_ovf", 8'd2, 64'h8);
        wr(8'd2, 64'h8);
        check("irq_w1c_edge", {63'd0, irq_o}, 64'd1);
        @(negedge clk_i);
        check("irq_cleared", {63'd0, irq_o}, 64'd0);
        rd("ovf_cleared", 8'd2, 64'd0);

        // Counter write beats a coincident increment.
        pmu_sig_i = 25'h20;
        repeat (2) @(negedge clk_i);
        pmu_sig_i = '0;
        wr(8'd21, 64'd100);
        repeat (3) @(negedge clk_i);
        rd("wrcoll_cnt5", 8'd21, 64'd100);

        // Hardware overflow set beats coincident W1C.
        wr(8'd19, 64'h0000_FFFF_FFFF_FFFF);
        pmu_sig_i = 25'h8;
        @(negedge clk_i);
        pmu_sig_i = '0;
        wr(8'd2, 64'h8);
        repeat (2) @(negedge clk_i);
        rd("ovfcoll_ovf", 8'd2, 64'h8);
        rd("ovfcoll_cnt3", 8'd19, 64'd0);

        // Back-to-back reads, unmapped addresses, reset with read in flight.
        wr(8'd16, 64'h1234);
        ra[0] = 8'd0;  re[0] = 64'd1;
        ra[1] = 8'd1;  re[1] = 64'h1FF_FFFF;
        ra[2] = 8'd16; re[2] = 64'h1234;
        ra[3] = 8'd99; re[3] = 64'd0;
        ra[4] = 8'd200; re[4] = 64'd0;
        req_i = 1'b1; we_i = 1'b0; addr_i = ra[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check($sformatf("b2b_rvalid_%0d", k), {63'd0, rvalid_o}, 64'd1);
            check($sformatf("b2b_rdata_%0d", k), rdata_o, re[k]);
            if (k < 4) addr_i = ra[k + 1];
        end
        rst_i = 1'b1;
        addr_i = 8'd0;
        @(negedge clk_i);
        check("rst_inflight_rvalid", {63'd0, rvalid_o}, 64'd0);
        check("rst_inflight_rdata", rdata_o, 64'd0);
        rst_i = 1'b0;
        req_i = 1'b0;

        // Clear-all with snapshot request.
        wr(8'd16, 64'd50);
        wr(8'd0, 64'h6);
        rd("clr_cnt0", 8'd16, 64'd0);
        rd("clr_ctrl", 8'd0, 64'd0);
`ifdef LAGARTO_PMU_SNAPSHOT_EN
        rd("snap0", 8'd64, 64'd50);
`else
        rd("nosnap_64", 8'd64, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
